// File: rtl/keypad_entry_ctrl_if.sv
// Keypad entry bus: raw keypad lines in, entry results and key strobes out.
interface keypad_entry_ctrl_if;
  logic [3:0] keypad_row;
  logic [3:0] keypad_col;
  logic [3:0] category;
  logic [9:0] new_value;
  logic       updated;
  logic       keypad_start;
  logic       keypad_accept;
  logic       keypad_backspace;
  logic       entry_active;
  logic       entry_error;

  // Master drives the keypad lines and observes the results.
  modport master (
    output keypad_row, keypad_col,
    input  category, new_value, updated, keypad_start, keypad_accept, keypad_backspace,
    input  entry_active, entry_error
  );

  // The entry controller itself.
  modport slave (
    input  keypad_row, keypad_col,
    output category, new_value, updated, keypad_start, keypad_accept, keypad_backspace,
    output entry_active, entry_error
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: decodes a 4x4 active-low keypad, debounces the key, and runs
// the Start -> category -> value digits -> Accept entry FSM with an idle timeout.
module keypad_entry_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 5000,
  parameter int unsigned NUM_CATEGORIES  = 8
) (
  input logic            clk,
  input logic            reset,
  keypad_entry_ctrl_if.slave bus
);

  localparam logic [3:0] KeyStart  = 4'd10;
  localparam logic [3:0] KeyAccept = 4'd11;
  localparam logic [3:0] KeyBack   = 4'd12;
  localparam logic [3:0] KeyNone   = 4'd15;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StGetCat = 2'd1;
  localparam logic [1:0] StGetVal = 2'd2;

  localparam logic [15:0] DebLimit = 16'(DEBOUNCE_CYCLES);
  localparam logic [31:0] TmoLimit = 32'(TIMEOUT_CYCLES);

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  logic [3:0]  dec_q, dec_d;
  logic [3:0]  last_q, last_d;
  logic [15:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]  stable_q, stable_d;
  logic        ev_q, ev_d;
  logic [3:0]  ev_key_q, ev_key_d;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cat_q, cat_d;
  logic [13:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] tmo_q, tmo_d;
  logic [3:0]  category_q, category_d;
  logic [9:0]  value_q, value_d;
  logic        updated_q, updated_d;
  logic        start_q, start_d;
  logic        accept_q, accept_d;
  logic        back_q, back_d;
  logic        error_q, error_d;

  // Decode the raw lines into a key code; anything but a single row/col pair is NONE.
  always_comb begin
    logic [3:0] rows;
    logic [3:0] cols;
    rows  = ~bus.keypad_row;
    cols  = ~bus.keypad_col;
    dec_d = KeyNone;
    if (is_onehot4(rows) && is_onehot4(cols)) begin
      unique case ({onehot_idx(rows), onehot_idx(cols)})
        4'b00_00: dec_d = 4'd1;
        4'b00_01: dec_d = 4'd2;
        4'b00_10: dec_d = 4'd3;
        4'b00_11: dec_d = KeyStart;
        4'b01_00: dec_d = 4'd4;
        4'b01_01: dec_d = 4'd5;
        4'b01_10: dec_d = 4'd6;
        4'b10_00: dec_d = 4'd7;
        4'b10_01: dec_d = 4'd8;
        4'b10_10: dec_d = 4'd9;
        4'b11_00: dec_d = 4'd0;
        4'b11_01: dec_d = KeyAccept;
        4'b11_10: dec_d = KeyBack;
        default:  dec_d = KeyNone;
      endcase
    end
  end

  // Debounce the decoded code and flag a press when the stable key leaves NONE.
  always_comb begin
    last_d = dec_q;
    if (dec_q == last_q) begin
      deb_cnt_d = (deb_cnt_q >= DebLimit) ? deb_cnt_q : deb_cnt_q + 16'd1;
    end else begin
      deb_cnt_d = 16'd1;
    end
    stable_d = (deb_cnt_d == DebLimit) ? dec_q : stable_q;
    ev_d     = (stable_q == KeyNone) && (stable_d != KeyNone);
    ev_key_d = stable_d;
  end

  // Entry FSM, timeout and registered outputs.
  always_comb begin
    state_d    = state_q;
    cat_d      = cat_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    category_d = category_q;
    value_d    = value_q;
    updated_d  = 1'b0;
    error_d    = 1'b0;
    start_d    = ev_q && (ev_key_q == KeyStart);
    accept_d   = ev_q && (ev_key_q == KeyAccept);
    back_d     = ev_q && (ev_key_q == KeyBack);
    tmo_d      = (state_q == StIdle || ev_q) ? 32'd0 : tmo_q + 32'd1;

    if (ev_q) begin
      unique case (state_q)
        StIdle: begin
          if (ev_key_q == KeyStart) state_d = StGetCat;
        end
        StGetCat: begin
          if (ev_key_q <= 4'd9) begin
            if (ev_key_q != 4'd0 && 32'(ev_key_q) <= NUM_CATEGORIES) begin
              cat_d   = ev_key_q;
              acc_d   = 14'd0;
              cnt_d   = 3'd0;
              state_d = StGetVal;
            end else begin
              error_d = 1'b1;
              state_d = StIdle;
            end
          end else if (ev_key_q == KeyBack) begin
            state_d = StIdle;
          end
        end
        StGetVal: begin
          if (ev_key_q <= 4'd9) begin
            if (cnt_q < 3'd4) begin
              acc_d = acc_q * 14'd10 + 14'(ev_key_q);
              cnt_d = cnt_q + 3'd1;
            end
          end else if (ev_key_q == KeyBack) begin
            if (cnt_q != 3'd0) begin
              acc_d = acc_q / 14'd10;
              cnt_d = cnt_q - 3'd1;
            end else begin
              state_d = StGetCat;
            end
          end else if (ev_key_q == KeyAccept) begin
            if (cnt_q != 3'd0) begin
              category_d = cat_q;
              value_d    = (acc_q > 14'd1023) ? 10'd1023 : acc_q[9:0];
              updated_d  = 1'b1;
            end else begin
              error_d = 1'b1;
            end
            state_d = StIdle;
          end else if (ev_key_q == KeyStart) begin
            state_d = StGetCat;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (TmoLimit != 32'd0 && state_q != StIdle && tmo_d >= TmoLimit) begin
      error_d = 1'b1;
      state_d = StIdle;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_q      <= KeyNone;
      last_q     <= KeyNone;
      deb_cnt_q  <= 16'd0;
      stable_q   <= KeyNone;
      ev_q       <= 1'b0;
      ev_key_q   <= KeyNone;
      state_q    <= StIdle;
      cat_q      <= 4'd0;
      acc_q      <= 14'd0;
      cnt_q      <= 3'd0;
      tmo_q      <= 32'd0;
      category_q <= 4'd0;
      value_q    <= 10'd0;
      updated_q  <= 1'b0;
      start_q    <= 1'b0;
      accept_q   <= 1'b0;
      back_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      dec_q      <= dec_d;
      last_q     <= last_d;
      deb_cnt_q  <= deb_cnt_d;
      stable_q   <= stable_d;
      ev_q       <= ev_d;
      ev_key_q   <= ev_key_d;
      state_q    <= state_d;
      cat_q      <= cat_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      category_q <= category_d;
      value_q    <= value_d;
      updated_q  <= updated_d;
      start_q    <= start_d;
      accept_q   <= accept_d;
      back_q     <= back_d;
      error_q    <= error_d;
    end
  end

  assign bus.category         = category_q;
  assign bus.new_value        = value_q;
  assign bus.updated          = updated_q;
  assign bus.keypad_start     = start_q;
  assign bus.keypad_accept    = accept_q;
  assign bus.keypad_backspace = back_q;
  assign bus.entry_error      = error_q;
  assign bus.entry_active     = (state_q != StIdle);

endmodule
